memory_arbiter: RTL and testbench

//  Sits directly below cpu: merges the imemory_* (fetch) and dmemory_* (load/store)

---
 rtl/memory_arbiter_pkg.sv | 25 ++
 rtl/memory_arbiter_checker.sv | 25 ++
 rtl/memory_arbiter_slot.sv | 54 +++++
 rtl/memory_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: grant states, request slot
// layout and watchdog counter width.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_type;

    typedef struct packed {
        logic        pending;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arb_slot_type;

    localparam int unsigned arb_timeout_width = 16;

    function automatic logic arb_is_busy(input arb_state_type s);
        return (s == IBUSY) || (s == DBUSY);
    endfunction

endpackage

// File: rtl/memory_arbiter_checker.sv
// Protocol checks for the arbiter: no new request on a side that still owns
// one, and memory_valid tracks the busy states.
module memory_arbiter_checker
    import memory_arbiter_pkg::*;
(
    input logic          clock,
    input logic          reset,
    input logic          imemory_valid,
    input logic          i_pending,
    input logic          dmemory_valid,
    input logic          d_pending,
    input arb_state_type state,
    input logic          memory_valid
);

    a_ifetch_overlap: assert property (@(posedge clock) disable iff (!reset)
        !(imemory_valid && i_pending));

    a_data_overlap: assert property (@(posedge clock) disable iff (!reset)
        !(dmemory_valid && d_pending));

    a_valid_matches_state: assert property (@(posedge clock) disable iff (!reset)
        memory_valid == arb_is_busy(state));

endmodule

// File: rtl/memory_arbiter_slot.sv
// One pending-request register. view_o forwards a request arriving this cycle
// so the arbiter can grant it at the same edge it is captured.
module memory_arbiter_slot
    import memory_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_i,
    input  logic         instr_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,
    input  logic [3:0]   wstrb_i,
    input  logic         clear_i,
    output arb_slot_type view_o,
    output logic         pending_o
);

    arb_slot_type slot_d, slot_q;

    // Capture a new request, or drop the slot when its transaction ends.
    always_comb begin
        slot_d = slot_q;
        if (valid_i) begin
            slot_d = '{pending: 1'b1, instr: instr_i, addr: addr_i,
                       wdata: wdata_i, wstrb: wstrb_i};
        end else if (clear_i) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q;
        end
    end

    // Slot storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Request view including a same-cycle arrival.
    always_comb begin
        if (valid_i) begin
            view_o = '{pending: 1'b1, instr: instr_i, addr: addr_i,
                       wdata: wdata_i, wstrb: wstrb_i};
        end else begin
            view_o = slot_q;
        end
    end

    assign pending_o = slot_q.pending;

endmodule

// File: rtl/memory_arbiter.sv
// Merges the fetch and data request ports onto one memory port, one transaction
// at a time. MEMORY_ARBITER_RR_EN selects round-robin instead of data-first priority.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,
    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        memory_timeout
);

    localparam logic WDOG_EN = (TIMEOUT_CYCLES > 32'd0);
    localparam logic [arb_timeout_width-1:0] WDOG_LAST =
        WDOG_EN ? arb_timeout_width'(TIMEOUT_CYCLES - 32'd1) : '0;

    arb_state_type                state_d, state_q;
    arb_slot_type                 mem_d, mem_q;
    logic [arb_timeout_width-1:0] cnt_d, cnt_q;

    arb_slot_type i_view_s, d_view_s;
    logic         i_pending_s, d_pending_s, i_clear_s, d_clear_s;
    logic         busy_s, timeout_s, finish_s, grant_i_s, grant_d_s, tie_i_s;

    memory_arbiter_slot u_islot (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (imemory_valid),
        .instr_i   (imemory_instr),
        .addr_i    (imemory_addr),
        .wdata_i   (imemory_wdata),
        .wstrb_i   (imemory_wstrb),
        .clear_i   (i_clear_s),
        .view_o    (i_view_s),
        .pending_o (i_pending_s)
    );

    memory_arbiter_slot u_dslot (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (dmemory_valid),
        .instr_i   (dmemory_instr),
        .addr_i    (dmemory_addr),
        .wdata_i   (dmemory_wdata),
        .wstrb_i   (dmemory_wstrb),
        .clear_i   (d_clear_s),
        .view_o    (d_view_s),
        .pending_o (d_pending_s)
    );

`ifdef MEMORY_ARBITER_RR_EN
    logic rr_next_d_d, rr_next_d_q;

    // Hand the next tie to whichever side was not granted last.
    always_comb begin
        rr_next_d_d = rr_next_d_q;
        if (grant_i_s) begin
            rr_next_d_d = 1'b1;
        end else if (grant_d_s) begin
            rr_next_d_d = 1'b0;
        end else begin
            rr_next_d_d = rr_next_d_q;
        end
    end

    // Round-robin pointer, data takes the first tie after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_next_d_q <= 1'b1;
        end else begin
            rr_next_d_q <= rr_next_d_d;
        end
    end

    assign tie_i_s = ~rr_next_d_q;
`else
    assign tie_i_s = 1'b0;
`endif

    // Completion, watchdog expiry and grant selection for this cycle.
    always_comb begin
        busy_s    = arb_is_busy(state_q);
        timeout_s = WDOG_EN && busy_s && !memory_ready && (cnt_q == WDOG_LAST);
        finish_s  = busy_s && (memory_ready || timeout_s);
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        i_clear_s = 1'b0;
        d_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_view_s.pending && d_view_s.pending) begin
                    grant_i_s = tie_i_s;
                    grant_d_s = ~tie_i_s;
                end else begin
                    grant_i_s = i_view_s.pending;
                    grant_d_s = d_view_s.pending;
                end
            end
            IBUSY: begin
                i_clear_s = finish_s;
                grant_d_s = finish_s && d_view_s.pending;
            end
            DBUSY: begin
                d_clear_s = finish_s;
                grant_i_s = finish_s && i_view_s.pending;
            end
            default: begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        endcase
    end

    // Next state: a grant loads the memory-port register straight from the slot view.
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        if (grant_i_s) begin
            state_d = IBUSY;
            mem_d   = i_view_s;
            cnt_d   = '0;
        end else if (grant_d_s) begin
            state_d = DBUSY;
            mem_d   = d_view_s;
            cnt_d   = '0;
        end else if (finish_s) begin
            state_d       = IDLE;
            mem_d.pending = 1'b0;
            cnt_d         = '0;
        end else if (busy_s && WDOG_EN) begin
            cnt_d = cnt_q + arb_timeout_width'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Grant FSM, memory-port request register and watchdog counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign memory_valid   = mem_q.pending;
    assign memory_instr   = mem_q.instr;
    assign memory_addr    = mem_q.addr;
    assign memory_wdata   = mem_q.wdata;
    assign memory_wstrb   = mem_q.wstrb;
    assign memory_timeout = timeout_s;

    // Responses return in the completing cycle; an aborted read returns all ones.
    assign imemory_ready = (state_q == IBUSY) && finish_s;
    assign dmemory_ready = (state_q == DBUSY) && finish_s;
    assign imemory_rdata = imemory_ready ? (timeout_s ? 32'hFFFF_FFFF : memory_rdata) : 32'h0;
    assign dmemory_rdata = dmemory_ready ? (timeout_s ? 32'hFFFF_FFFF : memory_rdata) : 32'h0;

    memory_arbiter_checker u_checker (
        .clock         (clock),
        .reset         (reset),
        .imemory_valid (imemory_valid),
        .i_pending     (i_pending_s),
        .dmemory_valid (dmemory_valid),
        .d_pending     (d_pending_s),
        .state         (state_q),
        .memory_valid  (memory_valid)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requests queue their expected grant and
// response, the memory responder pops and compares when the DUT grants/answers.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imemory_valid, imemory_instr, dmemory_valid, dmemory_instr;
    logic [31:0] imemory_addr, imemory_wdata, dmemory_addr, dmemory_wdata;
    logic [3:0]  imemory_wstrb, dmemory_wstrb;
    logic [31:0] imemory_rdata, dmemory_rdata;
    logic        imemory_ready, dmemory_ready;
    logic        memory_valid, memory_instr, memory_ready, memory_timeout;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;

    typedef struct {
        logic        is_d;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    memory_arbiter #(.TIMEOUT_CYCLES(32'd8)) dut (
        .reset(reset), .clock(clock),
        .imemory_valid(imemory_valid), .imemory_instr(imemory_instr),
        .imemory_addr(imemory_addr), .imemory_wdata(imemory_wdata),
        .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
        .imemory_ready(imemory_ready),
        .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr),
        .dmemory_addr(dmemory_addr), .dmemory_wdata(dmemory_wdata),
        .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
        .dmemory_ready(dmemory_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .memory_timeout(memory_timeout)
    );

    task automatic step();
        @(posedge clock);
        #1;
        imemory_valid = 1'b0;
        dmemory_valid = 1'b0;
    endtask

    task automatic drive_req(input logic is_d, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [31:0] rd);
        exp_t e;
        if (is_d) begin
            dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = addr;
            dmemory_wdata = wdata; dmemory_wstrb = wstrb;
        end else begin
            imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = addr;
            imemory_wdata = wdata; imemory_wstrb = wstrb;
        end
        e = '{is_d: is_d, instr: ~is_d, addr: addr, wdata: wdata, wstrb: wstrb, rdata: rd};
        exp_q.push_back(e);
    endtask

    // Memory responder: wait for a grant, hold ready low for n_wait samples, then answer.
    task automatic serve(input int n_wait);
        exp_t e;
        int   t;
        t = 0;
        while (memory_valid !== 1'b1 && t < 32) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (memory_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_wait: memory_valid=%b queued=%0d, required 1 with a queued request",
                     memory_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({memory_instr, memory_addr, memory_wdata, memory_wstrb} !== {e.instr, e.addr, e.wdata, e.wstrb}) begin
            errors++;
            $display("FAIL grant_fields: got instr=%b addr=%h wdata=%h wstrb=%b, want %b %h %h %b",
                     memory_instr, memory_addr, memory_wdata, memory_wstrb, e.instr, e.addr, e.wdata, e.wstrb);
        end
        for (int k = 0; k < n_wait; k++) begin
            @(negedge clock);
            checks++;
            if (memory_valid !== 1'b1 || memory_addr !== e.addr || memory_wdata !== e.wdata ||
                memory_wstrb !== e.wstrb || memory_instr !== e.instr || imemory_ready !== 1'b0 ||
                dmemory_ready !== 1'b0 || imemory_rdata !== 32'h0 || dmemory_rdata !== 32'h0 ||
                memory_timeout !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b addr=%h wdata=%h wstrb=%b ir=%b dr=%b to=%b, want stable %h %h %b, no ready",
                         memory_valid, memory_addr, memory_wdata, memory_wstrb, imemory_ready,
                         dmemory_ready, memory_timeout, e.addr, e.wdata, e.wstrb);
            end
        end
        @(posedge clock);
        #1;
        memory_ready = 1'b1;
        memory_rdata = e.rdata;
        @(negedge clock);
        checks++;
        if (e.is_d ? (dmemory_ready !== 1'b1 || dmemory_rdata !== e.rdata || imemory_ready !== 1'b0 || imemory_rdata !== 32'h0)
                   : (imemory_ready !== 1'b1 || imemory_rdata !== e.rdata || dmemory_ready !== 1'b0 || dmemory_rdata !== 32'h0)) begin
            errors++;
            $display("FAIL response: side_d=%b got ir=%b irdata=%h dr=%b drdata=%h, want rdata %h on owner only",
                     e.is_d, imemory_ready, imemory_rdata, dmemory_ready, dmemory_rdata, e.rdata);
        end
        @(posedge clock);
        #1;
        memory_ready = 1'b0;
        memory_rdata = 32'h1234_5678;
    endtask

    task automatic check_all_zero(input string name);
        logic [136:0] outs;
        outs = {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, imemory_ready,
                imemory_rdata, dmemory_ready, dmemory_rdata, memory_timeout};
        checks++;
        if (outs !== 137'd0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required all zero", name, outs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imemory_valid = 1'b0; imemory_instr = 1'b0; imemory_addr = 32'h0;
        imemory_wdata = 32'h0; imemory_wstrb = 4'h0;
        dmemory_valid = 1'b0; dmemory_instr = 1'b0; dmemory_addr = 32'h0;
        dmemory_wdata = 32'h0; dmemory_wstrb = 4'h0;
        memory_ready = 1'b1;
        memory_rdata = 32'h1234_5678;
        repeat (2) @(negedge clock);
        check_all_zero("reset_outputs");
        memory_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_single_fetch();
        drive_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0013);
        @(negedge clock);
        checks++;
        if (memory_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_valid: memory_valid=%b in request cycle, want 0", memory_valid);
        end
        step();
        checks++;
        if (memory_valid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_latency: memory_valid=%b one cycle after ivalid, want 1", memory_valid);
        end
        serve(2);
        step();
    endtask

    task automatic test_simultaneous();
        drive_req(1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF, 32'hAAAA_0001);
        drive_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'hBBBB_0002);
        step();
        serve(1);
        checks++;
        if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL no_bubble: valid=%b addr=%h right after dready, want 1 0x00002000",
                     memory_valid, memory_addr);
        end
        serve(1);
        step();
    endtask

    task automatic test_store();
        drive_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0000);
        step();
        serve(5);
        step();
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 4; p++) begin
            drive_req(1'b1, 32'h0000_4000 + 32'(p * 16), 32'(p), 4'hF, 32'hD000_0000 + 32'(p));
            drive_req(1'b0, 32'h0000_5000 + 32'(p * 16), 32'h0, 4'h0, 32'hF000_0000 + 32'(p));
            step();
            serve(p);
            checks++;
            if (memory_valid !== 1'b1 || memory_instr !== 1'b1) begin
                errors++;
                $display("FAIL pair_second_grant: pair %0d valid=%b instr=%b, want fetch granted at once",
                         p, memory_valid, memory_instr);
            end
            serve(1);
            step();
        end
    endtask

    task automatic test_arrive_on_complete();
        exp_t e;
        drive_req(1'b1, 32'h0000_6000, 32'h0, 4'h0, 32'h6666_0000);
        step();
        e = exp_q.pop_front();
        memory_ready = 1'b1;
        memory_rdata = e.rdata;
        drive_req(1'b0, 32'h0000_7000, 32'h0, 4'h0, 32'h7777_0000);
        @(negedge clock);
        checks++;
        if (dmemory_ready !== 1'b1 || dmemory_rdata !== e.rdata || imemory_ready !== 1'b0) begin
            errors++;
            $display("FAIL arrive_complete_resp: dr=%b drdata=%h ir=%b, want 1 %h 0",
                     dmemory_ready, dmemory_rdata, imemory_ready, e.rdata);
        end
        step();
        memory_ready = 1'b0;
        memory_rdata = 32'h1234_5678;
        checks++;
        if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_7000) begin
            errors++;
            $display("FAIL arrive_complete_grant: valid=%b addr=%h, want 1 0x00007000", memory_valid, memory_addr);
        end
        serve(0);
        step();
    endtask

    task automatic test_watchdog();
        exp_t e;
        drive_req(1'b1, 32'h0000_0F00, 32'h0, 4'h0, 32'hFFFF_FFFF);
        step();
        e = exp_q.pop_front();
        checks++;
        if (memory_valid !== 1'b1 || memory_addr !== e.addr) begin
            errors++;
            $display("FAIL wdog_grant: valid=%b addr=%h, want 1 %h", memory_valid, memory_addr, e.addr);
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            checks++;
            if (dmemory_ready !== 1'b0 || memory_timeout !== 1'b0 || memory_valid !== 1'b1) begin
                errors++;
                $display("FAIL wdog_early: busy cycle %0d dr=%b to=%b valid=%b, want 0 0 1",
                         c, dmemory_ready, memory_timeout, memory_valid);
            end
        end
        @(negedge clock);
        checks++;
        if (dmemory_ready !== 1'b1 || dmemory_rdata !== e.rdata || memory_timeout !== 1'b1 || imemory_ready !== 1'b0) begin
            errors++;
            $display("FAIL wdog_fire: dr=%b drdata=%h to=%b ir=%b, want 1 ffffffff 1 0",
                     dmemory_ready, dmemory_rdata, memory_timeout, imemory_ready);
        end
        @(negedge clock);
        checks++;
        if (memory_valid !== 1'b0 || memory_timeout !== 1'b0 || dmemory_ready !== 1'b0) begin
            errors++;
            $display("FAIL wdog_idle: valid=%b to=%b dr=%b after abort, want 0 0 0",
                     memory_valid, memory_timeout, dmemory_ready);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'hCAFE_F00D);
        step();
        @(negedge clock);
        #2;
        reset = 1'b0;
        memory_ready = 1'b1;
        memory_rdata = 32'hCAFE_F00D;
        #1;
        check_all_zero("reset_mid_outputs");
        void'(exp_q.pop_front());
        memory_ready = 1'b0;
        memory_rdata = 32'h1234_5678;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        drive_req(1'b0, 32'h0000_3004, 32'h0, 4'h0, 32'h0000_0093);
        step();
        serve(1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        memory_rdata = 32'h1234_5678;
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_back_to_back();
        test_arrive_on_complete();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
